// File: rtl/clarvi_split_sequencer_pkg.sv
// Shared types for the split-instruction issue path: ALU op codes, sequencer
// states and the beat-order rule that the ALU side must agree with.
package clarvi_split_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_OR,
        OP_AND,
        OP_SL,
        OP_SRL,
        OP_SRA,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR
    } op_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FIRST,
        SEQ_SECOND,
        SEQ_DONE
    } seq_state_t;

    // Compares and right shifts need the upper half resolved before the lower
    // half can be produced; W-forms always go low half first.
    function automatic logic part_high_first(input op_t op, input logic is32);
        logic hf;
        hf = 1'b0;
        if (!is32) begin
            case (op)
                OP_SLT, OP_SLTU, OP_SRL, OP_SRA: hf = 1'b1;
                default:                         hf = 1'b0;
            endcase
        end
        return hf;
    endfunction

endpackage

// File: rtl/clarvi_split_sequencer_if.sv
// Operand-in, ALU-beat and result-out bundle of the split sequencer.
interface clarvi_split_sequencer_if;
    import clarvi_split_sequencer_pkg::*;

    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic        in_is32;
    logic        in_imm_used;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic [63:0] in_imm;
    logic [63:0] in_pc;

    logic        alu_instr_part;
    op_t         alu_op;
    logic        alu_is32;
    logic        alu_imm_used;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_imm;
    logic [63:0] alu_pc;
    logic        alu_stall;
    logic [31:0] alu_result;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    modport slave (
        input  in_valid, in_op, in_is32, in_imm_used, in_rs1, in_rs2, in_imm, in_pc,
        output in_ready,
        output alu_instr_part, alu_op, alu_is32, alu_imm_used, alu_rs1, alu_rs2,
               alu_imm, alu_pc, alu_stall,
        input  alu_result,
        output out_valid, out_result,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_is32, in_imm_used, in_rs1, in_rs2, in_imm, in_pc,
        input  in_ready,
        input  alu_instr_part, alu_op, alu_is32, alu_imm_used, alu_rs1, alu_rs2,
               alu_imm, alu_pc, alu_stall,
        output alu_result,
        input  out_valid, out_result,
        output out_ready
    );

endinterface

// File: rtl/clarvi_split_sequencer.sv
// Drives one 64-bit ALU op through the 32-bit ALU as two half-width beats and
// assembles the two half results into a 64-bit writeback value.
module clarvi_split_sequencer
    import clarvi_split_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_RESULT = 64'h0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    clarvi_split_sequencer_if.slave  bus
);

    seq_state_t  state_reg, state_next;
    op_t         op_reg;
    logic        is32_reg;
    logic        imm_used_reg;
    logic        high_first_reg;
    logic [63:0] rs1_reg, rs2_reg, imm_reg, pc_reg;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] hi_reg, hi_next;
    logic [63:0] result_reg, result_next;

    logic accept;
    logic part;

    assign accept = (state_reg == SEQ_IDLE) && bus.in_valid && !stall;

    always_comb begin
        part = 1'b0;
        case (state_reg)
            SEQ_FIRST:  part = high_first_reg;
            SEQ_SECOND: part = !high_first_reg;
            default:    part = 1'b0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        lo_next     = lo_reg;
        hi_next     = hi_reg;
        result_next = result_reg;
        case (state_reg)
            SEQ_IDLE: begin
                if (accept) state_next = SEQ_FIRST;
            end
            SEQ_FIRST, SEQ_SECOND: begin
                if (!stall) begin
                    if (part) hi_next = bus.alu_result;
                    else      lo_next = bus.alu_result;
                    if (state_reg == SEQ_FIRST) begin
                        state_next = SEQ_SECOND;
                    end else begin
                        // Latch the assembled value so it cannot move while waiting on out_ready.
                        result_next = {hi_next, lo_next};
                        state_next  = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                if (bus.out_ready) state_next = SEQ_IDLE;
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= SEQ_IDLE;
            lo_reg         <= 32'h0;
            hi_reg         <= 32'h0;
            result_reg     <= RESET_RESULT;
            op_reg         <= OP_ADD;
            is32_reg       <= 1'b0;
            imm_used_reg   <= 1'b0;
            high_first_reg <= 1'b0;
            rs1_reg        <= 64'h0;
            rs2_reg        <= 64'h0;
            imm_reg        <= 64'h0;
            pc_reg         <= 64'h0;
        end else begin
            state_reg  <= state_next;
            lo_reg     <= lo_next;
            hi_reg     <= hi_next;
            result_reg <= result_next;
            if (accept) begin
                op_reg         <= bus.in_op;
                is32_reg       <= bus.in_is32;
                imm_used_reg   <= bus.in_imm_used;
                high_first_reg <= part_high_first(bus.in_op, bus.in_is32);
                rs1_reg        <= bus.in_rs1;
                rs2_reg        <= bus.in_rs2;
                imm_reg        <= bus.in_imm;
                pc_reg         <= bus.in_pc;
            end
        end
    end

    // The ALU keeps carry/compare state between beats, so it only advances on live beats.
    assign bus.alu_stall      = stall || !((state_reg == SEQ_FIRST) || (state_reg == SEQ_SECOND));
    assign bus.alu_instr_part = part;
    assign bus.alu_op         = op_reg;
    assign bus.alu_is32       = is32_reg;
    assign bus.alu_imm_used   = imm_used_reg;
    assign bus.alu_rs1        = part ? rs1_reg[63:32] : rs1_reg[31:0];
    assign bus.alu_rs2        = part ? rs2_reg[63:32] : rs2_reg[31:0];
    assign bus.alu_imm        = part ? imm_reg[63:32] : imm_reg[31:0];
    assign bus.alu_pc         = pc_reg;

    assign bus.in_ready   = (state_reg == SEQ_IDLE);
    assign bus.out_valid  = (state_reg == SEQ_DONE);
    assign bus.out_result = result_reg;

endmodule

// File: tb/tb_clarvi_split_sequencer.sv
// Directed bench: a small beat-level 32-bit ALU model answers the sequencer,
// and every op result is compared against hand-computed 64-bit values.
module tb_clarvi_split_sequencer;
    import clarvi_split_sequencer_pkg::*;

    localparam logic [63:0] RST_VAL = 64'hDEAD_BEEF_0000_0001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;

    clarvi_split_sequencer_if bus();

    clarvi_split_sequencer #(.RESET_RESULT(RST_VAL)) dut (
        .clock (clock),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Beat-level ALU model with the carry/compare/shift state that spans beats.
    logic        m_carry, m_decided, m_lt;
    logic [31:0] m_saved_hi, m_low_w;
    logic [4:0]  shamt;
    logic        n_carry, n_decided, n_lt;
    logic [31:0] n_saved_hi, n_low_w;
    logic [31:0] a_v, b_v, bb_v, r_v;
    logic [32:0] sum_v;

    always_comb begin
        a_v        = bus.alu_rs1;
        b_v        = bus.alu_imm_used ? bus.alu_imm : bus.alu_rs2;
        bb_v       = (bus.alu_op == OP_SUB) ? ~b_v : b_v;
        sum_v      = 33'h0;
        r_v        = b_v;
        n_carry    = m_carry;
        n_decided  = m_decided;
        n_lt       = m_lt;
        n_saved_hi = m_saved_hi;
        n_low_w    = m_low_w;
        case (bus.alu_op)
            OP_ADD, OP_SUB: begin
                if (!bus.alu_instr_part) begin
                    sum_v   = {1'b0, a_v} + {1'b0, bb_v} + {32'h0, (bus.alu_op == OP_SUB)};
                    r_v     = sum_v[31:0];
                    n_carry = sum_v[32];
                    n_low_w = sum_v[31:0];
                end else if (bus.alu_is32) begin
                    r_v = {32{m_low_w[31]}};
                end else begin
                    sum_v = {1'b0, a_v} + {1'b0, bb_v} + {32'h0, m_carry};
                    r_v   = sum_v[31:0];
                end
            end
            OP_XOR: r_v = a_v ^ b_v;
            OP_OR:  r_v = a_v | b_v;
            OP_AND: r_v = a_v & b_v;
            OP_SLT, OP_SLTU: begin
                if (bus.alu_instr_part) begin
                    r_v       = 32'h0;
                    n_decided = (a_v != b_v);
                    n_lt      = (bus.alu_op == OP_SLT) ? ($signed(a_v) < $signed(b_v)) : (a_v < b_v);
                end else begin
                    r_v = {31'h0, m_decided ? m_lt : (a_v < b_v)};
                end
            end
            OP_SRL, OP_SRA: begin
                if (bus.alu_instr_part) begin
                    r_v        = (bus.alu_op == OP_SRA) ? 32'($signed(a_v) >>> shamt) : (a_v >> shamt);
                    n_saved_hi = a_v;
                end else begin
                    r_v = (a_v >> shamt) | ((shamt == 5'd0) ? 32'h0 : (m_saved_hi << (6'd32 - {1'b0, shamt})));
                end
            end
            default: r_v = b_v;
        endcase
        bus.alu_result = r_v;
    end

    always @(posedge clock) begin
        if (reset) begin
            m_carry    <= 1'b0;
            m_decided  <= 1'b0;
            m_lt       <= 1'b0;
            m_saved_hi <= 32'h0;
            m_low_w    <= 32'h0;
        end else if (!bus.alu_stall) begin
            m_carry    <= n_carry;
            m_decided  <= n_decided;
            m_lt       <= n_lt;
            m_saved_hi <= n_saved_hi;
            m_low_w    <= n_low_w;
        end
    end

    typedef struct {
        op_t         op;
        logic        is32;
        logic        imm_used;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic        first;
        logic [63:0] result;
    } vec_t;

    vec_t vecs[11];
    vec_t hv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_op       = v.op;
        bus.in_is32     = v.is32;
        bus.in_imm_used = v.imm_used;
        bus.in_rs1      = v.rs1;
        bus.in_rs2      = v.rs2;
        bus.in_imm      = v.imm;
        bus.in_pc       = 64'h8000_0000 + 64'(vec_cnt);
        shamt           = v.rs2[4:0];
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the output handshake.
    task automatic run_vec(input int idx, input vec_t v, input int sf, input int ss, input int rd);
        logic [63:0] held;
        logic [31:0] rs1_half;
        int lat;
        drive(v);
        bus.in_valid = 1'b1;
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 1;
        rs1_half = v.first ? v.rs1[63:32] : v.rs1[31:0];
        chk("first_part", 64'(bus.alu_instr_part), 64'(v.first));
        chk("first_rs1", 64'(bus.alu_rs1), 64'(rs1_half));
        chk("first_alu_stall", 64'(bus.alu_stall), 64'd0);
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < sf; i++) begin
            stall = 1'b1;
            #1;
            chk("stall_first_alu_stall", 64'(bus.alu_stall), 64'd1);
            @(negedge clock);
            lat++;
            chk("stall_first_part_held", 64'(bus.alu_instr_part), 64'(v.first));
        end
        stall = 1'b0;
        @(negedge clock);
        lat++;
        chk("second_part", 64'(bus.alu_instr_part), 64'(!v.first));
        chk("second_alu_stall", 64'(bus.alu_stall), 64'd0);
        for (int i = 0; i < ss; i++) begin
            stall = 1'b1;
            #1;
            chk("stall_second_alu_stall", 64'(bus.alu_stall), 64'd1);
            @(negedge clock);
            lat++;
            chk("stall_second_part_held", 64'(bus.alu_instr_part), 64'(!v.first));
            chk("stall_second_no_valid", 64'(bus.out_valid), 64'd0);
        end
        stall = 1'b0;
        do begin
            @(negedge clock);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk("latency", 64'(lat), 64'(3 + sf + ss));
        held = bus.out_result;
        for (int i = 0; i < rd; i++) begin
            @(negedge clock);
            chk("hold_result", bus.out_result, held);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        chk("result", bus.out_result, v.result);
        $display("vec %0d op=%s rs1=%h rs2=%h result=%h latency=%0d", idx, v.op.name(), v.rs1,
                 v.rs2, bus.out_result, lat);
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk("post_valid", 64'(bus.out_valid), 64'd0);
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        //            op       is32  immu  rs1                     rs2                     imm    first result
        vecs[0]  = '{OP_ADD,  1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1,                  64'h0, 1'b0, 64'h0000_0001_0000_0000};
        vecs[1]  = '{OP_SLT,  1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'h1,                  64'h0, 1'b1, 64'h1};
        vecs[2]  = '{OP_SLTU, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'h1,                  64'h0, 1'b1, 64'h0};
        vecs[3]  = '{OP_ADD,  1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'h55,                 64'h1, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vecs[4]  = '{OP_SUB,  1'b0, 1'b0, 64'h0,                   64'h1,                  64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{OP_XOR,  1'b0, 1'b0, 64'hF0F0_0000_FFFF_0000, 64'h0FF0_1234_00FF_0000, 64'h0, 1'b0, 64'hFF00_1234_FF00_0000};
        vecs[6]  = '{OP_SRA,  1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h4,                  64'h0, 1'b1, 64'hF800_0000_0000_0000};
        vecs[7]  = '{OP_SLTU, 1'b0, 1'b0, 64'h1,                   64'h2,                  64'h0, 1'b1, 64'h1};
        vecs[8]  = '{OP_SLT,  1'b0, 1'b0, 64'h5,                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0};
        vecs[9]  = '{OP_SUB,  1'b1, 1'b0, 64'h0,                   64'h1,                  64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[10] = '{OP_AND,  1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b0, 64'h0F0F_0000_0F0F_0000};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_result", bus.out_result, RST_VAL);
        chk("rst_alu_stall", 64'(bus.alu_stall), 64'd1);
        chk("rst_alu_part", 64'(bus.alu_instr_part), 64'd0);

        // Stall in IDLE must block acceptance.
        stall = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clock);
        chk("idle_stall_no_accept", 64'(bus.in_ready), 64'd1);
        chk("idle_stall_alu_stall", 64'(bus.alu_stall), 64'd1);
        bus.in_valid = 1'b0;
        stall = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i], 0, 0, 0);

        // SRL by 4 with two stalled cycles during the second beat.
        hv = '{OP_SRL, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h4, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF};
        run_vec(11, hv, 0, 2, 0);
        // Stall across the first-to-second edge, then writeback holds off three cycles.
        run_vec(12, vecs[0], 1, 0, 3);
        // Back-to-back accept straight after the handshake.
        run_vec(13, vecs[1], 0, 0, 0);

        // Reset while the second beat is in flight discards the op.
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        @(negedge clock);
        chk("pre_reset_second_part", 64'(bus.alu_instr_part), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_result", bus.out_result, RST_VAL);
        chk("mid_rst_alu_stall", 64'(bus.alu_stall), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("discarded_no_valid", 64'(bus.out_valid), 64'd0);
        end
        hv = '{OP_ADD, 1'b0, 1'b0, 64'h1, 64'h1, 64'h0, 1'b0, 64'h2};
        run_vec(14, hv, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clarvi_split_sequencer.md
Name: clarvi_split_sequencer

Overview:
Issue side of the split-instruction datapath. Accepts one RV64 ALU operation with 64-bit operands and drives it into the 32-bit ALU as two half-width beats (instr_part 0 = low half, 1 = high half), in the order the op requires. Collects both 32-bit results, assembles the 64-bit writeback value and presents it on a valid/ready output. Sits between decode/operand-fetch and writeback, next to the ALU it drives.

Parameters:
RESET_RESULT, 64'h0, value of out_result after reset.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  pipeline stall; freezes the FSM and ALU state
in_valid  in  1  operation offered
in_ready  out  1  sequencer can accept (IDLE only)
in_op  in  op_t  ALU op (ADD, SUB, SLT, SLTU, XOR, OR, AND, SL, SRL, SRA, LUI, AUIPC, JAL, JALR)
in_is32  in  1  W-form op (32-bit result, sign-extended)
in_imm_used  in  1  operand 2 is the immediate
in_rs1  in  64  source 1
in_rs2  in  64  source 2
in_imm  in  64  sign-extended immediate
in_pc  in  64  instruction PC
alu_instr_part  out  1  beat half select
alu_op  out  op_t  registered op
alu_is32  out  1  registered is32
alu_imm_used  out  1  registered imm_used
alu_rs1  out  32  selected half of rs1
alu_rs2  out  32  selected half of rs2
alu_imm  out  32  selected half of imm
alu_pc  out  64  registered PC
alu_stall  out  1  ALU state-register hold
alu_result  in  32  ALU combinational result for the current beat
out_valid  out  1  64-bit result available
out_ready  in  1  writeback accepts
out_result  out  64  assembled result

Behaviour:
- FSM states: IDLE, FIRST, SECOND, DONE. Reset (synchronous, active-high) enters IDLE. Reset values: out_valid=0, in_ready=1, out_result=RESET_RESULT, alu_stall=1, alu_instr_part=0.
- IDLE: in_ready=1. On in_valid && !stall, register all in_* fields and go to FIRST. stall in IDLE blocks acceptance.
- Part order, decided at accept:
  - HIGH_FIRST (part 1 then part 0) for 64-bit SLT, SLTU, SRL, SRA.
  - LOW_FIRST (part 0 then part 1) for every other op and for every op with in_is32=1.
- FIRST: alu_instr_part = first part. alu_rs1, alu_rs2 and alu_imm select bits [31:0] for part 0 and [63:32] for part 1. If !stall, capture alu_result into the matching half register and go to SECOND.
- SECOND: drive the other part and capture alu_result into the other half register. If !stall, go to DONE.
- alu_stall = stall || state not in {FIRST, SECOND}. This keeps the ALU carry/compare state register untouched outside the beats and across a stall. The two beats update ALU state in order with no intervening update.
- DONE: out_valid=1, out_result={hi,lo}. On out_ready, go to IDLE. out_result and out_valid must not change while out_ready=0.
- out_valid is asserted exactly 3 non-stalled cycles after the accept edge. Throughput is one op per 4 cycles. The output handshake is independent of stall.
- Assembly is a pure concatenation; no arithmetic happens in this block. SLT/SLTU high beat returns 0, so the result is zero-extended. W ops take the upper half from the ALU sign-extension beat.
- Boundary conditions:
  - Reset in any state returns to IDLE next cycle and discards the in-flight op; no out_valid is produced for it.
  - stall on the FIRST→SECOND edge holds the state and beat outputs unchanged, and the half register is not written.
  - in_valid while busy is ignored; in_ready=0.

Decomposition:
- op_t and instr_t stay in riscv.svh.
- Add to riscv.svh: the FSM state enum seq_state_t and function part_high_first(op_t, logic is32) returning the order bit, shared with the ALU bench model.
- No sub-module. The parent instantiates clarvi_ALU alongside and packs the alu_* fields into instr_t.

Test Plan:
1. ADD, rs1=64'h0000_0000_FFFF_FFFF, rs2=1, imm_used=0 → beats part 0 then 1; out_result=64'h0000_0001_0000_0000; out_valid 3 cycles after accept.
2. SLT, rs1=64'hFFFF_FFFF_0000_0000, rs2=64'h1 → beats part 1 then 0; out_result=64'h1. SLTU with the same operands → 64'h0.
3. ADDW (is32=1), rs1=64'h7FFF_FFFF, imm=1, imm_used=1 → part 0 then 1; out_result=64'hFFFF_FFFF_8000_0000.
4. SRL by 4, rs1=64'h1234_5678_9ABC_DEF0 with stall high 2 cycles during SECOND → alu_stall=1 and beat outputs held; out_result=64'h0123_4567_89AB_CDEF; out_valid delayed by 2.
5. out_ready low 3 cycles in DONE → out_result stable and in_ready=0. Next op is accepted the cycle after out_ready=1 in IDLE.
6. Reset asserted in SECOND → next cycle IDLE, out_valid=0, in_ready=1, out_result=RESET_RESULT; a following ADD 1+1 gives 64'h2.
